bm_chain_builder: RTL and testbench

Enqueue-side producer for the buffer-manager linked list. Accepts a packet as a stream of buffer-sized segments, pops one free buffer pointer per segment, and issues the data-memory write pointer. It emits the `enq_buf_valid`/`enq_buf_ptr_cur`/`enq_buf_ptr_nxt` link writes that chain consecutive buffers. At end of packet it emits a descriptor (head, tail, length, buffer count) toward the queueing/ASA path.

---
 rtl/bm_chain_builder.sv | 250 +++++++++++++++++++++++++
 tb/tb_bm_chain_builder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bm_chain_builder.sv
// Enqueue-side chain builder: pops one free buffer per accepted segment, links
// consecutive buffers of a packet and emits a per-packet descriptor.
module bm_chain_builder #(
  parameter int BUF_PTR_NBITS       = 10,
  parameter int BUF_SIZE            = 64,
  parameter int SEG_BYTES_NBITS     = 7,
  parameter int PACKET_LENGTH_NBITS = 14,
  parameter int BCNT_NBITS          = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_seg_valid,
  input  logic                           i_seg_sop,
  input  logic                           i_seg_eop,
  input  logic [SEG_BYTES_NBITS-1:0]     i_seg_bytes,
  output logic                           o_seg_ready,
  input  logic                           i_free_buf_valid,
  input  logic [BUF_PTR_NBITS-1:0]       i_free_buf_ptr,
  output logic                           o_free_buf_rd,
  output logic                           o_buf_wr_valid,
  output logic [BUF_PTR_NBITS-1:0]       o_buf_wr_ptr,
  output logic                           o_enq_buf_valid,
  output logic [BUF_PTR_NBITS-1:0]       o_enq_buf_ptr_cur,
  output logic [BUF_PTR_NBITS-1:0]       o_enq_buf_ptr_nxt,
  output logic                           o_desc_valid,
  output logic [BUF_PTR_NBITS-1:0]       o_desc_head_ptr,
  output logic [BUF_PTR_NBITS-1:0]       o_desc_tail_ptr,
  output logic [PACKET_LENGTH_NBITS-1:0] o_desc_packet_length,
  output logic [BCNT_NBITS-1:0]          o_desc_buf_count,
  output logic                           o_desc_err,
  output logic [15:0]                    o_drop_cnt
);

  localparam int SUM_W = PACKET_LENGTH_NBITS + 1;
  localparam logic [SEG_BYTES_NBITS-1:0] FULL_SEG = SEG_BYTES_NBITS'(BUF_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IN_PKT = 2'd1,
    ST_TRUNC  = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic                           w_seg_ready;
  logic                           w_pop;
  logic                           w_drop;
  logic                           w_trunc;
  logic                           w_in_pkt;
  logic [SUM_W-1:0]               w_len_sum;
  logic                           w_len_ovf;
  logic [PACKET_LENGTH_NBITS-1:0] w_len_new;
  logic [BCNT_NBITS-1:0]          w_cnt_base;
  logic                           w_cnt_sat;
  logic [BCNT_NBITS-1:0]          w_cnt_new;
  logic                           w_err_new;
  logic [BUF_PTR_NBITS-1:0]       w_head_new;

  logic [BUF_PTR_NBITS-1:0]       r_head;
  logic [BUF_PTR_NBITS-1:0]       r_tail;
  logic [PACKET_LENGTH_NBITS-1:0] r_len;
  logic [BCNT_NBITS-1:0]          r_cnt;
  logic                           r_err;

  logic                           r_buf_wr_valid;
  logic [BUF_PTR_NBITS-1:0]       r_buf_wr_ptr;
  logic                           r_enq_valid;
  logic [BUF_PTR_NBITS-1:0]       r_enq_cur;
  logic [BUF_PTR_NBITS-1:0]       r_enq_nxt;
  logic                           r_desc_valid;
  logic [BUF_PTR_NBITS-1:0]       r_desc_head;
  logic [BUF_PTR_NBITS-1:0]       r_desc_tail;
  logic [PACKET_LENGTH_NBITS-1:0] r_desc_len;
  logic [BCNT_NBITS-1:0]          r_desc_cnt;
  logic                           r_desc_err;
  logic [15:0]                    r_drop_cnt;

  // A segment is malformed if empty, oversized, or short without being the last.
  function automatic logic seg_malformed(input logic [SEG_BYTES_NBITS-1:0] bytes,
                                         input logic eop);
    logic bad;
    bad = 1'b0;
    if (bytes == {SEG_BYTES_NBITS{1'b0}}) begin
      bad = 1'b1;
    end else if (bytes > FULL_SEG) begin
      bad = 1'b1;
    end else if (!eop && (bytes != FULL_SEG)) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, ready and accept qualifiers.
  always_comb begin
    w_state_nxt = r_state;
    w_seg_ready = 1'b0;
    w_pop       = 1'b0;
    w_drop      = 1'b0;
    w_trunc     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // orphans are swallowed without needing a free buffer
        if (!i_seg_sop) begin
          w_seg_ready = 1'b1;
        end else begin
          w_seg_ready = i_free_buf_valid;
        end
        w_pop  = i_seg_valid & w_seg_ready & i_seg_sop;
        w_drop = i_seg_valid & ~i_seg_sop;
        if (w_pop && !i_seg_eop) begin
          w_state_nxt = ST_IN_PKT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IN_PKT: begin
        w_seg_ready = i_free_buf_valid & ~i_seg_sop;
        w_pop       = i_seg_valid & w_seg_ready;
        w_trunc     = i_seg_valid & i_seg_sop;
        if (w_trunc) begin
          w_state_nxt = ST_TRUNC;
        end else if (w_pop && i_seg_eop) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_IN_PKT;
        end
      end
      ST_TRUNC: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Packet context as it would be after absorbing the offered segment.
  assign w_in_pkt   = (r_state == ST_IN_PKT);
  assign w_len_sum  = (w_in_pkt ? {1'b0, r_len} : {SUM_W{1'b0}}) + SUM_W'(i_seg_bytes);
  assign w_len_ovf  = w_len_sum[SUM_W-1];
  assign w_len_new  = w_len_ovf ? {PACKET_LENGTH_NBITS{1'b1}} : w_len_sum[PACKET_LENGTH_NBITS-1:0];
  assign w_cnt_base = w_in_pkt ? r_cnt : {BCNT_NBITS{1'b0}};
  assign w_cnt_sat  = &w_cnt_base;
  assign w_cnt_new  = w_cnt_sat ? w_cnt_base : w_cnt_base + BCNT_NBITS'(1);
  assign w_err_new  = (w_in_pkt & r_err) | seg_malformed(i_seg_bytes, i_seg_eop)
                    | w_len_ovf | w_cnt_sat;
  assign w_head_new = w_in_pkt ? r_head : i_free_buf_ptr;

  // Running context of the packet being built.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head <= {BUF_PTR_NBITS{1'b0}};
      r_tail <= {BUF_PTR_NBITS{1'b0}};
      r_len  <= {PACKET_LENGTH_NBITS{1'b0}};
      r_cnt  <= {BCNT_NBITS{1'b0}};
      r_err  <= 1'b0;
    end else if (w_pop) begin
      r_head <= w_head_new;
      r_tail <= i_free_buf_ptr;
      r_len  <= w_len_new;
      r_cnt  <= w_cnt_new;
      r_err  <= w_err_new;
    end else begin
      r_head <= r_head;
    end
  end

  // Registered strobes: data write, link write, descriptor, orphan counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf_wr_valid <= 1'b0;
      r_buf_wr_ptr   <= {BUF_PTR_NBITS{1'b0}};
      r_enq_valid    <= 1'b0;
      r_enq_cur      <= {BUF_PTR_NBITS{1'b0}};
      r_enq_nxt      <= {BUF_PTR_NBITS{1'b0}};
      r_desc_valid   <= 1'b0;
      r_desc_head    <= {BUF_PTR_NBITS{1'b0}};
      r_desc_tail    <= {BUF_PTR_NBITS{1'b0}};
      r_desc_len     <= {PACKET_LENGTH_NBITS{1'b0}};
      r_desc_cnt     <= {BCNT_NBITS{1'b0}};
      r_desc_err     <= 1'b0;
      r_drop_cnt     <= 16'd0;
    end else begin
      r_buf_wr_valid <= w_pop;
      if (w_pop) begin
        r_buf_wr_ptr <= i_free_buf_ptr;
      end else begin
        r_buf_wr_ptr <= r_buf_wr_ptr;
      end
      r_enq_valid <= w_pop & w_in_pkt;
      if (w_pop && w_in_pkt) begin
        r_enq_cur <= r_tail;
        r_enq_nxt <= i_free_buf_ptr;
      end else begin
        r_enq_cur <= r_enq_cur;
      end
      if (w_pop && i_seg_eop) begin
        r_desc_valid <= 1'b1;
        r_desc_head  <= w_head_new;
        r_desc_tail  <= i_free_buf_ptr;
        r_desc_len   <= w_len_new;
        r_desc_cnt   <= w_cnt_new;
        r_desc_err   <= w_err_new;
      end else if (w_trunc) begin
        r_desc_valid <= 1'b1;
        r_desc_head  <= r_head;
        r_desc_tail  <= r_tail;
        r_desc_len   <= r_len;
        r_desc_cnt   <= r_cnt;
        r_desc_err   <= 1'b1;
      end else begin
        r_desc_valid <= 1'b0;
        r_desc_err   <= 1'b0;
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end else begin
        r_drop_cnt <= r_drop_cnt;
      end
    end
  end

  assign o_seg_ready          = w_seg_ready;
  assign o_free_buf_rd        = w_pop;
  assign o_buf_wr_valid       = r_buf_wr_valid;
  assign o_buf_wr_ptr         = r_buf_wr_ptr;
  assign o_enq_buf_valid      = r_enq_valid;
  assign o_enq_buf_ptr_cur    = r_enq_cur;
  assign o_enq_buf_ptr_nxt    = r_enq_nxt;
  assign o_desc_valid         = r_desc_valid;
  assign o_desc_head_ptr      = r_desc_head;
  assign o_desc_tail_ptr      = r_desc_tail;
  assign o_desc_packet_length = r_desc_len;
  assign o_desc_buf_count     = r_desc_cnt;
  assign o_desc_err           = r_desc_err;
  assign o_drop_cnt           = r_drop_cnt;

endmodule

// File: tb/tb_bm_chain_builder.sv
// Directed bench for bm_chain_builder; expected strobes are queued with the
// cycle they must appear in and matched by a negedge monitor.
module tb_bm_chain_builder;
  localparam int PW = 10;
  localparam int SW = 7;
  localparam int LW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          seg_valid, seg_sop, seg_eop, free_buf_valid;
  logic [SW-1:0] seg_bytes;
  logic [PW-1:0] free_buf_ptr;
  logic          seg_ready, free_buf_rd, buf_wr_valid, enq_valid, desc_valid, desc_err;
  logic [PW-1:0] buf_wr_ptr, enq_cur, enq_nxt, desc_head, desc_tail;
  logic [LW-1:0] desc_len;
  logic [CW-1:0] desc_cnt;
  logic [15:0]   drop_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ocyc  = 0;

  typedef struct { int c; logic [PW-1:0] p; } wr_t;
  typedef struct { int c; logic [PW-1:0] cur; logic [PW-1:0] nxt; } link_t;
  typedef struct { int c; logic [PW-1:0] h; logic [PW-1:0] t; logic [LW-1:0] len;
                   logic [CW-1:0] cnt; logic err; } desc_t;
  wr_t   wr_q[$];
  link_t link_q[$];
  desc_t desc_q[$];

  bm_chain_builder #(
    .BUF_PTR_NBITS(PW), .BUF_SIZE(64), .SEG_BYTES_NBITS(SW),
    .PACKET_LENGTH_NBITS(LW), .BCNT_NBITS(CW)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_seg_valid(seg_valid), .i_seg_sop(seg_sop), .i_seg_eop(seg_eop),
    .i_seg_bytes(seg_bytes), .o_seg_ready(seg_ready),
    .i_free_buf_valid(free_buf_valid), .i_free_buf_ptr(free_buf_ptr),
    .o_free_buf_rd(free_buf_rd),
    .o_buf_wr_valid(buf_wr_valid), .o_buf_wr_ptr(buf_wr_ptr),
    .o_enq_buf_valid(enq_valid), .o_enq_buf_ptr_cur(enq_cur), .o_enq_buf_ptr_nxt(enq_nxt),
    .o_desc_valid(desc_valid), .o_desc_head_ptr(desc_head), .o_desc_tail_ptr(desc_tail),
    .o_desc_packet_length(desc_len), .o_desc_buf_count(desc_cnt),
    .o_desc_err(desc_err), .o_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic push_wr(input int c, input logic [PW-1:0] p);
    wr_q.push_back('{c: c, p: p});
  endtask

  task automatic push_link(input int c, input logic [PW-1:0] cur, input logic [PW-1:0] nxt);
    link_q.push_back('{c: c, cur: cur, nxt: nxt});
  endtask

  task automatic push_desc(input int c, input logic [PW-1:0] h, input logic [PW-1:0] t,
                           input logic [LW-1:0] len, input logic [CW-1:0] cnt, input logic err);
    desc_q.push_back('{c: c, h: h, t: t, len: len, cnt: cnt, err: err});
  endtask

  // One cycle of stimulus; ready/pop are combinational so they are checked right away.
  task automatic drive(input logic v, input logic s, input logic e, input logic [SW-1:0] b,
                       input logic fv, input logic [PW-1:0] fp,
                       input logic want_rdy, input logic want_rd);
    @(negedge clk);
    seg_valid = v; seg_sop = s; seg_eop = e; seg_bytes = b;
    free_buf_valid = fv; free_buf_ptr = fp;
    #1;
    ocyc = cyc + 1;
    check("seg_ready", {31'd0, seg_ready}, {31'd0, want_rdy});
    check("free_buf_rd", {31'd0, free_buf_rd}, {31'd0, want_rd});
  endtask

  task automatic acc(input logic s, input logic e, input logic [SW-1:0] b, input logic [PW-1:0] p);
    drive(1'b1, s, e, b, 1'b1, p, 1'b1, 1'b1);
    push_wr(ocyc, p);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 10'd0, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    wr_t w; link_t l; desc_t d;
    if (buf_wr_valid) begin
      if (wr_q.size() == 0) check("wr_unexpected", {31'd0, buf_wr_valid}, 32'd0);
      else begin
        w = wr_q.pop_front();
        check("wr_cycle", cyc, w.c);
        check("wr_ptr", {22'd0, buf_wr_ptr}, {22'd0, w.p});
      end
    end
    if (enq_valid) begin
      if (link_q.size() == 0) check("link_unexpected", {31'd0, enq_valid}, 32'd0);
      else begin
        l = link_q.pop_front();
        check("link_cycle", cyc, l.c);
        check("link_cur", {22'd0, enq_cur}, {22'd0, l.cur});
        check("link_nxt", {22'd0, enq_nxt}, {22'd0, l.nxt});
      end
    end
    if (desc_valid) begin
      if (desc_q.size() == 0) check("desc_unexpected", {31'd0, desc_valid}, 32'd0);
      else begin
        d = desc_q.pop_front();
        check("desc_cycle", cyc, d.c);
        check("desc_head", {22'd0, desc_head}, {22'd0, d.h});
        check("desc_tail", {22'd0, desc_tail}, {22'd0, d.t});
        check("desc_len", {24'd0, desc_len}, {24'd0, d.len});
        check("desc_cnt", {24'd0, desc_cnt}, {24'd0, d.cnt});
        check("desc_err", {31'd0, desc_err}, {31'd0, d.err});
      end
    end
    while (wr_q.size() != 0 && wr_q[0].c < cyc) begin
      check("wr_missing_cycle", cyc, wr_q[0].c);
      void'(wr_q.pop_front());
    end
    while (link_q.size() != 0 && link_q[0].c < cyc) begin
      check("link_missing_cycle", cyc, link_q[0].c);
      void'(link_q.pop_front());
    end
    while (desc_q.size() != 0 && desc_q[0].c < cyc) begin
      check("desc_missing_cycle", cyc, desc_q[0].c);
      void'(desc_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; seg_valid = 1'b0; seg_sop = 1'b0; seg_eop = 1'b0;
    seg_bytes = 7'd0; free_buf_valid = 1'b0; free_buf_ptr = 10'd0;
    repeat (3) @(negedge clk);
    // reset state
    check("rst_wr_valid", {31'd0, buf_wr_valid}, 32'd0);
    check("rst_enq_valid", {31'd0, enq_valid}, 32'd0);
    check("rst_desc_valid", {31'd0, desc_valid}, 32'd0);
    check("rst_desc_err", {31'd0, desc_err}, 32'd0);
    check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check("rst_wr_ptr", {22'd0, buf_wr_ptr}, 32'd0);
    check("rst_desc_len", {24'd0, desc_len}, 32'd0);
    check("rst_ready_nonsop", {31'd0, seg_ready}, 32'd1);
    seg_sop = 1'b1; #1;
    check("rst_ready_sop_nofree", {31'd0, seg_ready}, 32'd0);
    @(negedge clk); rst = 1'b0; seg_sop = 1'b0;

    // single-segment packet
    acc(1'b1, 1'b1, 7'd40, 10'd5); push_desc(ocyc, 10'd5, 10'd5, 8'd40, 8'd1, 1'b0);

    // three-segment packet, back to back
    acc(1'b1, 1'b0, 7'd64, 10'd7);
    acc(1'b0, 1'b0, 7'd64, 10'd3); push_link(ocyc, 10'd7, 10'd3);
    acc(1'b0, 1'b1, 7'd10, 10'd9); push_link(ocyc, 10'd3, 10'd9);
    push_desc(ocyc, 10'd7, 10'd9, 8'd138, 8'd3, 1'b0);

    // short non-eop segment
    acc(1'b1, 1'b0, 7'd32, 10'd11);
    acc(1'b0, 1'b1, 7'd64, 10'd12); push_link(ocyc, 10'd11, 10'd12);
    push_desc(ocyc, 10'd11, 10'd12, 8'd96, 8'd2, 1'b1);

    // sop mid-packet truncates
    acc(1'b1, 1'b0, 7'd64, 10'd1);
    acc(1'b0, 1'b0, 7'd64, 10'd2); push_link(ocyc, 10'd1, 10'd2);
    drive(1'b1, 1'b1, 1'b0, 7'd64, 1'b1, 10'd20, 1'b0, 1'b0);
    push_desc(ocyc, 10'd1, 10'd2, 8'd128, 8'd2, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 7'd64, 1'b1, 10'd20, 1'b0, 1'b0);
    acc(1'b1, 1'b0, 7'd64, 10'd20);
    acc(1'b0, 1'b1, 7'd64, 10'd21); push_link(ocyc, 10'd20, 10'd21);
    push_desc(ocyc, 10'd20, 10'd21, 8'd128, 8'd2, 1'b0);

    // orphans in IDLE, even without a free buffer
    repeat (3) drive(1'b1, 1'b0, 1'b0, 7'd64, 1'b0, 10'd0, 1'b1, 1'b0);
    idle();
    check("drop_cnt_3", {16'd0, drop_cnt}, 32'd3);

    // free list empty: sop in IDLE and mid-packet stall
    drive(1'b1, 1'b1, 1'b1, 7'd40, 1'b0, 10'd0, 1'b0, 1'b0);
    acc(1'b1, 1'b0, 7'd64, 10'd30);
    repeat (2) drive(1'b1, 1'b0, 1'b1, 7'd64, 1'b0, 10'd0, 1'b0, 1'b0);
    acc(1'b0, 1'b1, 7'd64, 10'd31); push_link(ocyc, 10'd30, 10'd31);
    push_desc(ocyc, 10'd30, 10'd31, 8'd128, 8'd2, 1'b0);

    // length overflow clamps at 255
    acc(1'b1, 1'b0, 7'd64, 10'd40);
    for (int i = 41; i < 44; i++) begin
      acc(1'b0, 1'b0, 7'd64, PW'(i)); push_link(ocyc, PW'(i - 1), PW'(i));
    end
    acc(1'b0, 1'b1, 7'd64, 10'd44); push_link(ocyc, 10'd43, 10'd44);
    push_desc(ocyc, 10'd40, 10'd44, 8'd255, 8'd5, 1'b1);

    // empty and oversized single segments
    acc(1'b1, 1'b1, 7'd0, 10'd70);  push_desc(ocyc, 10'd70, 10'd70, 8'd0, 8'd1, 1'b1);
    acc(1'b1, 1'b1, 7'd100, 10'd71); push_desc(ocyc, 10'd71, 10'd71, 8'd100, 8'd1, 1'b1);

    // reset mid-packet discards the packet
    acc(1'b1, 1'b0, 7'd64, 10'd50);
    acc(1'b0, 1'b0, 7'd64, 10'd51); push_link(ocyc, 10'd50, 10'd51);
    @(negedge clk); rst = 1'b1; seg_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 7'd64, 1'b1, 10'd0, 1'b1, 1'b0);
    idle();
    check("drop_cnt_after_rst", {16'd0, drop_cnt}, 32'd1);
    acc(1'b1, 1'b1, 7'd20, 10'd60); push_desc(ocyc, 10'd60, 10'd60, 8'd20, 8'd1, 1'b0);

    // buffer count saturates at 255 over 260 segments
    acc(1'b1, 1'b0, 7'd64, 10'd0);
    for (int i = 1; i < 259; i++) begin
      acc(1'b0, 1'b0, 7'd64, PW'(i)); push_link(ocyc, PW'(i - 1), PW'(i));
    end
    acc(1'b0, 1'b1, 7'd64, 10'd259); push_link(ocyc, 10'd258, 10'd259);
    push_desc(ocyc, 10'd0, 10'd259, 8'd255, 8'd255, 1'b1);

    repeat (3) idle();
    check("wr_q_drained", wr_q.size(), 32'd0);
    check("link_q_drained", link_q.size(), 32'd0);
    check("desc_q_drained", desc_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
